imem_loader: RTL and testbench

Instruction-memory writer for the pipelined CPU. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words. It issues one write per word into the instruction memory that the fetch stage reads, starting at the reset PC address. While loading it holds the CPU, so fetch never sees a partially written program.

---
 rtl/imem_loader.sv | 230 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Writes a program into the instruction memory from a byte stream. The stream
// is a 16-bit big-endian word count N followed by N big-endian 32-bit words.
// When the macro IMEM_LOADER_CHECKSUM_EN is defined, a trailing XOR checksum
// byte (over the data bytes only) is also required. While a load is in
// progress, busy is asserted so the CPU is held and fetch never sees a
// partially written program.
//
// Parameters:
//   DEPTH      instruction memory capacity in words
//   BASE_ADDR  byte address of word 0 (the fetch reset PC)
//
// Ports:
//   clk           clock
//   reset         synchronous, active-high reset
//   start         one-cycle load request, honoured in IDLE / DONE / ERR
//   byte_valid    byte_data carries a stream byte
//   byte_data     stream byte
//   byte_ready    a byte is accepted this cycle when byte_valid is high
//   wr_en         one-cycle instruction-memory write strobe
//   wr_addr       byte address of the write
//   wr_data       assembled 32-bit word
//   words_loaded  number of words written in the current load
//   busy          load in progress (CPU hold)
//   done          sticky: the load completed
//   err           sticky: the load was aborted
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int unsigned DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic [15:0] words_loaded,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_LEN_HI = 3'd1;
   localparam logic [2:0] ST_LEN_LO = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef IMEM_LOADER_CHECKSUM_EN
   localparam logic [2:0] ST_CHK    = 3'd4;
`endif
   localparam logic [2:0] ST_DONE   = 3'd5;
   localparam logic [2:0] ST_ERR    = 3'd6;

   logic [2:0]  state_q,   state_d;
   logic [15:0] len_q,     len_d;
   logic [1:0]  cnt_q,     cnt_d;
   logic [23:0] asm_q,     asm_d;     // first three bytes of the current word
   logic [15:0] words_q,   words_d;
   logic        wr_en_q,   wr_en_d;
   logic [31:0] wr_addr_q, wr_addr_d;
   logic [31:0] wr_data_q, wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]  chk_q,     chk_d;
`endif

   logic        in_load_s;
   logic        accept_s;
   logic [15:0] len_full_s;

   // Decode which states belong to an active load.
   always_comb begin
      in_load_s = 1'b0;
      case (state_q)
         ST_LEN_HI, ST_LEN_LO, ST_DATA: in_load_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK:                        in_load_s = 1'b1;
`endif
         default:                       in_load_s = 1'b0;
      endcase
   end

   assign accept_s   = byte_valid && in_load_s;
   assign len_full_s = {len_q[15:8], byte_data};

   // Next-state logic: stream parsing, word assembly and write generation.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      cnt_d     = cnt_q;
      asm_d     = asm_q;
      words_d   = words_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_d     = chk_q;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_LEN_HI;
               words_d = 16'd0;
               cnt_d   = 2'd0;
               asm_d   = 24'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d   = 8'd0;
`endif
            end else begin
               state_d = state_q;
            end
         end
         ST_LEN_HI: begin
            if (accept_s) begin
               len_d   = {byte_data, 8'h00};
               state_d = ST_LEN_LO;
            end else begin
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_LO: begin
            if (accept_s) begin
               len_d = len_full_s;
               if ({16'd0, len_full_s} > DEPTH) begin
                  state_d = ST_ERR;
               end else if (len_full_s == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state_d = ST_CHK;
`else
                  state_d = ST_DONE;
`endif
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_LEN_LO;
            end
         end
         ST_DATA: begin
            if (accept_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               chk_d = chk_q ^ byte_data;
`endif
               if (cnt_q == 2'd3) begin
                  // Fourth byte completes the word: register the write now
                  // so the strobe appears exactly one cycle later.
                  cnt_d     = 2'd0;
                  wr_en_d   = 1'b1;
                  wr_data_d = {asm_q, byte_data};
                  wr_addr_d = BASE_ADDR + {14'd0, words_q, 2'b00};
                  words_d   = words_q + 16'd1;
                  if ((words_q + 16'd1) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                     state_d = ST_CHK;
`else
                     state_d = ST_DONE;
`endif
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  cnt_d = cnt_q + 2'd1;
                  asm_d = {asm_q[15:0], byte_data};
               end
            end else begin
               state_d = ST_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CHK: begin
            if (accept_s) begin
               if (byte_data == chk_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
               end
            end else begin
               state_d = ST_CHK;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         len_q     <= 16'd0;
         cnt_q     <= 2'd0;
         asm_q     <= 24'd0;
         words_q   <= 16'd0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= BASE_ADDR;
         wr_data_q <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         cnt_q     <= cnt_d;
         asm_q     <= asm_d;
         words_q   <= words_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk_q     <= chk_d;
`endif
      end
   end

   assign byte_ready   = in_load_s;
   assign busy         = in_load_s;
   assign done         = (state_q == ST_DONE);
   assign err          = (state_q == ST_ERR);
   assign wr_en        = wr_en_q;
   assign wr_addr      = wr_addr_q;
   assign wr_data      = wr_data_q;
   assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Directed testbench for imem_loader. Inputs change on the falling edge;
// a monitor logs every write strobe 2 time units after each rising edge and
// flags any strobe longer than one cycle. Works with and without
// IMEM_LOADER_CHECKSUM_EN defined.
// -----------------------------------------------------------------------------
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic [15:0] words_loaded;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   logic [31:0] wa[$];
   logic [31:0] wd[$];
   int          wr_long = 0;
   logic        prev_wr = 1'b0;

   imem_loader #(.DEPTH(4096), .BASE_ADDR(32'h0000_3000)) dut (
      .clk(clk), .reset(reset), .start(start),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .words_loaded(words_loaded), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Write monitor
   always @(posedge clk) begin
      #2;
      if (wr_en === 1'b1) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
         if (prev_wr === 1'b1) wr_long++;
      end
      prev_wr = wr_en;
   end

   // Overall time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic send(input logic [7:0] b, input int gap);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wr_long = 0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({byte_ready, wr_en, busy, done, err} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got rdy,wr,busy,done,err=%b required 00000",
                  {byte_ready, wr_en, busy, done, err});
      end
      checks++;
      if (wr_addr !== 32'h0000_3000 || wr_data !== 32'h0 || words_loaded !== 16'd0) begin
         errors++;
         $display("FAIL reset_regs: got addr=%h data=%h words=%0d required 00003000/00000000/0",
                  wr_addr, wr_data, words_loaded);
      end
   endtask

   task automatic test_basic();
      logic [7:0] s [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'h9A, 8'hBC, 8'hDE, 8'hF0};
      clear_log();
      pulse_start();
      checks++;
      if (byte_ready !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_start: got ready=%b busy=%b required 1 1", byte_ready, busy);
      end
      for (int i = 0; i < 10; i++) send(s[i], 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      checks++;
      if (wr_en !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL basic_last_word: got wr=%b done=%b busy=%b required 1 0 1", wr_en, done, busy);
      end
      send(8'h00, 0);
`else
      checks++;
      if (wr_en !== 1'b1 || done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_last_word: got wr=%b done=%b busy=%b required 1 1 0", wr_en, done, busy);
      end
`endif
      @(negedge clk);
      checks++;
      if (wa.size() !== 2) begin
         errors++;
         $display("FAIL basic_count: got %0d writes required 2", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 32'h0000_3000 || wd[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL basic_wr0: got %h<-%h required 00003000<-12345678", wa[0], wd[0]);
         end
         checks++;
         if (wa[1] !== 32'h0000_3004 || wd[1] !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL basic_wr1: got %h<-%h required 00003004<-9abcdef0", wa[1], wd[1]);
         end
      end
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || words_loaded !== 16'd2) begin
         errors++;
         $display("FAIL basic_end: got done=%b err=%b busy=%b words=%0d required 1 0 0 2",
                  done, err, busy, words_loaded);
      end
   endtask

   task automatic test_zero();
      clear_log();
      pulse_start();
      send(8'h00, 0);
      send(8'h00, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00, 0);
`endif
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 16'd0) begin
         errors++;
         $display("FAIL zero_end: got done=%b err=%b words=%0d required 1 0 0", done, err, words_loaded);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (wa.size() !== 0) begin
         errors++;
         $display("FAIL zero_nowrite: got %0d writes required 0", wa.size());
      end
   endtask

   task automatic test_overflow();
      clear_log();
      pulse_start();
      send(8'h10, 0);
      send(8'h01, 0);
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ovf_err: got err=%b busy=%b done=%b required 1 0 0", err, busy, done);
      end
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      #1;
      checks++;
      if (byte_ready !== 1'b0) begin
         errors++;
         $display("FAIL ovf_ready: got %b required 0", byte_ready);
      end
      @(negedge clk);
      byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (wa.size() !== 0 || words_loaded !== 16'd0 || err !== 1'b1) begin
         errors++;
         $display("FAIL ovf_nowrite: got writes=%0d words=%0d err=%b required 0 0 1",
                  wa.size(), words_loaded, err);
      end
   endtask

   task automatic test_gaps();
      logic [7:0] s [10] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'h9A, 8'hBC, 8'hDE, 8'hF0};
      clear_log();
      pulse_start();
      for (int i = 0; i < 10; i++) begin
         send(s[i], 0);
         if (i == 4) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (2) @(negedge clk);
         end else begin
            repeat (3) @(negedge clk);
         end
         if (i == 5) begin
            checks++;
            if (busy !== 1'b1 || words_loaded !== 16'd1) begin
               errors++;
               $display("FAIL gaps_start_ignored: got busy=%b words=%0d required 1 1", busy, words_loaded);
            end
         end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00, 3);
`endif
      checks++;
      if (wa.size() !== 2) begin
         errors++;
         $display("FAIL gaps_count: got %0d writes required 2", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 32'h0000_3000 || wd[0] !== 32'h1234_5678 ||
             wa[1] !== 32'h0000_3004 || wd[1] !== 32'h9ABC_DEF0) begin
            errors++;
            $display("FAIL gaps_data: got %h<-%h %h<-%h required 00003000<-12345678 00003004<-9abcdef0",
                     wa[0], wd[0], wa[1], wd[1]);
         end
      end
      checks++;
      if (wr_long !== 0) begin
         errors++;
         $display("FAIL gaps_pulse: got %0d long strobes required 0", wr_long);
      end
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || words_loaded !== 16'd2) begin
         errors++;
         $display("FAIL gaps_end: got done=%b err=%b words=%0d required 1 0 2", done, err, words_loaded);
      end
   endtask

   task automatic test_reset_midload();
      clear_log();
      pulse_start();
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'h12, 0);
      send(8'h34, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if ({byte_ready, wr_en, busy, done, err} !== 5'b00000 || wr_addr !== 32'h0000_3000 ||
          wr_data !== 32'h0 || words_loaded !== 16'd0) begin
         errors++;
         $display("FAIL midrst_state: got flags=%b addr=%h data=%h words=%0d required 00000/00003000/0/0",
                  {byte_ready, wr_en, busy, done, err}, wr_addr, wr_data, words_loaded);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wa.size() !== 0) begin
         errors++;
         $display("FAIL midrst_nowrite: got %0d writes required 0", wa.size());
      end
      pulse_start();
      send(8'h00, 0);
      send(8'h01, 0);
      send(8'hAA, 0);
      send(8'hBB, 0);
      send(8'hCC, 0);
      send(8'hDD, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
      send(8'h00, 0);
`endif
      @(negedge clk);
      checks++;
      if (wa.size() !== 1) begin
         errors++;
         $display("FAIL midrst_reload_count: got %0d writes required 1", wa.size());
      end else begin
         checks++;
         if (wa[0] !== 32'h0000_3000 || wd[0] !== 32'hAABB_CCDD) begin
            errors++;
            $display("FAIL midrst_reload: got %h<-%h required 00003000<-aabbccdd", wa[0], wd[0]);
         end
      end
      checks++;
      if (done !== 1'b1 || words_loaded !== 16'd1) begin
         errors++;
         $display("FAIL midrst_done: got done=%b words=%0d required 1 1", done, words_loaded);
      end
   endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
   task automatic test_bad_checksum();
      logic [7:0] s [11] = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78,
                             8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h01};
      clear_log();
      pulse_start();
      for (int i = 0; i < 11; i++) send(s[i], 0);
      @(negedge clk);
      checks++;
      if (wa.size() !== 2) begin
         errors++;
         $display("FAIL badchk_count: got %0d writes required 2", wa.size());
      end
      checks++;
      if (err !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL badchk_err: got err=%b done=%b busy=%b required 1 0 0", err, done, busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero();
      test_overflow();
      test_gaps();
      test_reset_midload();
`ifdef IMEM_LOADER_CHECKSUM_EN
      test_bad_checksum();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
